// File: rtl/mem_port_arbiter.sv
// Single-outstanding memory port arbiter for fetch, load and store-FIFO drain.
// Stores drain before loads, and fetch gets forced priority after FETCH_MAX_WAIT lost grants.
module mem_port_arbiter #(
  parameter int FETCH_MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] mem_fetch_addr,
  input  logic        mem_fetch_addr_en,
  output logic [31:0] mem_inst_in,
  output logic        mem_inst_valid,
  output logic        mem_inst_access_fault,
  input  logic [31:0] mem_data_addr,
  input  logic        mem_data_addr_valid,
  input  logic [1:0]  mem_data_size,
  output logic [31:0] mem_data_in,
  output logic        mem_data_valid,
  output logic        mem_data_access_fault,
  input  logic        sfifo_empty,
  input  logic [31:0] sfifo_addr,
  input  logic [31:0] sfifo_val,
  input  logic [1:0]  sfifo_size,
  output logic        sfifo_pop,
  output logic        store_fault,
  output logic [31:0] store_fault_addr,
  output logic [31:0] port_addr,
  output logic [31:0] port_wdata,
  output logic [1:0]  port_size,
  output logic        port_we,
  output logic        port_req,
  input  logic        port_ready,
  input  logic [31:0] port_rdata,
  input  logic        port_rvalid,
  input  logic        port_fault
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_FETCH, OWN_LOAD, OWN_STORE} owner_t;

  localparam logic [3:0] MAX_WAIT = 4'(FETCH_MAX_WAIT);

  state_t      state, state_next;
  owner_t      owner, grant_owner;
  logic        grant;
  logic [3:0]  starve_cnt;
  logic [31:0] fetch_addr_q;
  logic        fetch_live;

  // A fetch response is only useful if the pipeline still wants the same address.
  assign fetch_live = mem_fetch_addr_en && (mem_fetch_addr == fetch_addr_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      owner <= OWN_FETCH;
    end else begin
      state <= state_next;
      owner <= grant_owner;
    end
  end

  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_owner = owner;
    case (state)
      IDLE: begin
        if (mem_fetch_addr_en && (starve_cnt >= MAX_WAIT)) begin
          grant       = 1'b1;
          grant_owner = OWN_FETCH;
        end else if (!sfifo_empty) begin
          grant       = 1'b1;
          grant_owner = OWN_STORE;
        end else if (mem_data_addr_valid) begin
          grant       = 1'b1;
          grant_owner = OWN_LOAD;
        end else if (mem_fetch_addr_en) begin
          grant       = 1'b1;
          grant_owner = OWN_FETCH;
        end
        if (grant) state_next = REQ;
      end
      REQ:     if (port_ready)  state_next = WAIT;
      WAIT:    if (port_rvalid) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      port_addr             <= '0;
      port_wdata            <= '0;
      port_size             <= '0;
      port_we               <= 1'b0;
      port_req              <= 1'b0;
      fetch_addr_q          <= '0;
      starve_cnt            <= '0;
      mem_inst_in           <= '0;
      mem_inst_valid        <= 1'b0;
      mem_inst_access_fault <= 1'b0;
      mem_data_in           <= '0;
      mem_data_valid        <= 1'b0;
      mem_data_access_fault <= 1'b0;
      sfifo_pop             <= 1'b0;
      store_fault           <= 1'b0;
      store_fault_addr      <= '0;
    end else begin
      mem_inst_valid <= 1'b0;
      mem_data_valid <= 1'b0;
      sfifo_pop      <= 1'b0;
      store_fault    <= 1'b0;

      if (grant) begin
        port_req <= 1'b1;
        port_we  <= (grant_owner == OWN_STORE);
        case (grant_owner)
          OWN_STORE: begin
            port_addr  <= sfifo_addr;
            port_size  <= sfifo_size;
            port_wdata <= sfifo_val;
          end
          OWN_LOAD: begin
            port_addr  <= mem_data_addr;
            port_size  <= mem_data_size;
            port_wdata <= '0;
          end
          default: begin
            port_addr    <= mem_fetch_addr;
            port_size    <= 2'd2;
            port_wdata   <= '0;
            fetch_addr_q <= mem_fetch_addr;
          end
        endcase
        // Losing a grant only counts while fetch is actually asking.
        if ((grant_owner == OWN_FETCH) || !mem_fetch_addr_en)
          starve_cnt <= '0;
        else if (starve_cnt != 4'hF)
          starve_cnt <= starve_cnt + 4'd1;
      end

      if ((state == REQ) && port_ready)
        port_req <= 1'b0;

      if ((state == WAIT) && port_rvalid) begin
        case (owner)
          OWN_STORE: begin
            sfifo_pop <= 1'b1;
            if (port_fault) begin
              store_fault      <= 1'b1;
              store_fault_addr <= port_addr;
            end
          end
          OWN_LOAD: begin
            mem_data_valid        <= 1'b1;
            mem_data_in           <= port_rdata;
            mem_data_access_fault <= port_fault;
          end
          default: begin
            if (fetch_live) begin
              mem_inst_valid        <= 1'b1;
              mem_inst_in           <= port_rdata;
              mem_inst_access_fault <= port_fault;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a responding memory-port model
// and a scoreboard of expected response pulses.
module tb_mem_port_arbiter;

  localparam logic [2:0] K_INST  = 3'b100;
  localparam logic [2:0] K_DATA  = 3'b010;
  localparam logic [2:0] K_STORE = 3'b001;

  typedef struct packed {
    logic [2:0]  kind;
    logic [31:0] data;
    logic        fault;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_fetch_addr;
  logic        mem_fetch_addr_en;
  logic [31:0] mem_inst_in;
  logic        mem_inst_valid;
  logic        mem_inst_access_fault;
  logic [31:0] mem_data_addr;
  logic        mem_data_addr_valid;
  logic [1:0]  mem_data_size;
  logic [31:0] mem_data_in;
  logic        mem_data_valid;
  logic        mem_data_access_fault;
  logic        sfifo_empty;
  logic [31:0] sfifo_addr;
  logic [31:0] sfifo_val;
  logic [1:0]  sfifo_size;
  logic        sfifo_pop;
  logic        store_fault;
  logic [31:0] store_fault_addr;
  logic [31:0] port_addr;
  logic [31:0] port_wdata;
  logic [1:0]  port_size;
  logic        port_we;
  logic        port_req;
  logic        port_ready  = 1'b0;
  logic [31:0] port_rdata  = '0;
  logic        port_rvalid = 1'b0;
  logic        port_fault  = 1'b0;

  int          checks = 0;
  int          errors = 0;
  resp_t       exp_q[$];
  int          resp_delay = 0;
  logic        busy = 1'b0;
  int          wait_cnt = 0;
  logic [31:0] acc_addr = '0;

  mem_port_arbiter #(.FETCH_MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .mem_fetch_addr(mem_fetch_addr), .mem_fetch_addr_en(mem_fetch_addr_en),
    .mem_inst_in(mem_inst_in), .mem_inst_valid(mem_inst_valid),
    .mem_inst_access_fault(mem_inst_access_fault),
    .mem_data_addr(mem_data_addr), .mem_data_addr_valid(mem_data_addr_valid),
    .mem_data_size(mem_data_size), .mem_data_in(mem_data_in),
    .mem_data_valid(mem_data_valid), .mem_data_access_fault(mem_data_access_fault),
    .sfifo_empty(sfifo_empty), .sfifo_addr(sfifo_addr), .sfifo_val(sfifo_val),
    .sfifo_size(sfifo_size), .sfifo_pop(sfifo_pop), .store_fault(store_fault),
    .store_fault_addr(store_fault_addr),
    .port_addr(port_addr), .port_wdata(port_wdata), .port_size(port_size),
    .port_we(port_we), .port_req(port_req), .port_ready(port_ready),
    .port_rdata(port_rdata), .port_rvalid(port_rvalid), .port_fault(port_fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    return (a == 32'h0000_0100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, want);
    end
  endtask

  task automatic applyStimulus(input logic fen, input logic [31:0] faddr,
                               input logic lv, input logic [31:0] laddr, input logic [1:0] lsize,
                               input logic empty, input logic [31:0] saddr,
                               input logic [31:0] sval, input logic [1:0] ssize);
    mem_fetch_addr_en   = fen;
    mem_fetch_addr      = faddr;
    mem_data_addr_valid = lv;
    mem_data_addr       = laddr;
    mem_data_size       = lsize;
    sfifo_empty         = empty;
    sfifo_addr          = saddr;
    sfifo_val           = sval;
    sfifo_size          = ssize;
  endtask

  // Waits (bounded) for the selected DUT signal to be high at a falling edge.
  task automatic waitFor(input int sel, input string tag);
    logic seen;
    logic sig;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      case (sel)
        0:       sig = port_req;
        1:       sig = sfifo_pop;
        2:       sig = mem_data_valid;
        default: sig = mem_inst_valid;
      endcase
      if (sig) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput(tag, {31'd0, seen}, 32'd1);
  endtask

  // Memory port model: accepts one cycle after port_req, answers resp_delay cycles later.
  always @(negedge clk) begin
    port_rvalid = 1'b0;
    port_fault  = 1'b0;
    if (port_ready) begin
      port_ready = 1'b0;
      busy       = 1'b1;
      wait_cnt   = resp_delay;
    end else if (!busy && port_req) begin
      port_ready = 1'b1;
      acc_addr   = port_addr;
    end
    if (busy) begin
      if (wait_cnt == 0) begin
        port_rvalid = 1'b1;
        port_rdata  = memModel(acc_addr);
        port_fault  = acc_addr[31];
        busy        = 1'b0;
      end else begin
        wait_cnt--;
      end
    end
  end

  // Scoreboard: every response pulse must match the oldest expected entry.
  always @(negedge clk) begin
    logic [2:0]  k_obs;
    logic [31:0] d_obs;
    logic        f_obs;
    resp_t       want;
    k_obs = {mem_inst_valid, mem_data_valid, sfifo_pop};
    if (k_obs != 3'b000) begin
      if (k_obs == K_INST) begin
        d_obs = mem_inst_in;
        f_obs = mem_inst_access_fault;
      end else if (k_obs == K_DATA) begin
        d_obs = mem_data_in;
        f_obs = mem_data_access_fault;
      end else begin
        d_obs = store_fault ? store_fault_addr : 32'd0;
        f_obs = store_fault;
      end
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", {29'd0, k_obs}, 32'd0);
      end else begin
        want = exp_q.pop_front();
        checkOutput("resp_kind", {29'd0, k_obs}, {29'd0, want.kind});
        checkOutput("resp_data", d_obs, want.data);
        checkOutput("resp_fault", {31'd0, f_obs}, {31'd0, want.fault});
      end
    end
  end

  initial begin
    logic [31:0] starve_seq [6];
    starve_seq = '{32'h600, 32'h600, 32'h600, 32'h600, 32'h500, 32'h600};

    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, 2'd0, 1'b1, '0, '0, 2'd0);
    repeat (3) @(negedge clk);
    checkOutput("reset_port_req", {31'd0, port_req}, 32'd0);
    checkOutput("reset_port_we", {31'd0, port_we}, 32'd0);
    checkOutput("reset_pulses", {28'd0, mem_inst_valid, mem_data_valid, sfifo_pop, store_fault}, 32'd0);
    checkOutput("reset_port_addr", port_addr, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Fetch only, minimum latency.
    applyStimulus(1'b1, 32'h100, 1'b0, '0, 2'd0, 1'b1, '0, '0, 2'd0);
    exp_q.push_back('{K_INST, 32'hDEAD_BEEF, 1'b0});
    @(negedge clk);
    checkOutput("fetch_req_c1", {31'd0, port_req}, 32'd1);
    checkOutput("fetch_addr", port_addr, 32'h100);
    checkOutput("fetch_size", {30'd0, port_size}, 32'd2);
    checkOutput("fetch_we", {31'd0, port_we}, 32'd0);
    @(negedge clk);
    checkOutput("fetch_req_drop", {31'd0, port_req}, 32'd0);
    @(negedge clk);
    checkOutput("fetch_valid_c3", {31'd0, mem_inst_valid}, 32'd1);
    checkOutput("fetch_data", mem_inst_in, 32'hDEAD_BEEF);
    applyStimulus(1'b0, '0, 1'b0, '0, 2'd0, 1'b1, '0, '0, 2'd0);
    repeat (2) @(negedge clk);

    // Pending store must go before a load to the same address.
    applyStimulus(1'b0, '0, 1'b1, 32'h200, 2'd1, 1'b0, 32'h200, 32'h11, 2'd2);
    exp_q.push_back('{K_STORE, 32'd0, 1'b0});
    exp_q.push_back('{K_DATA, memModel(32'h200), 1'b0});
    @(negedge clk);
    checkOutput("store_first_we", {31'd0, port_we}, 32'd1);
    checkOutput("store_addr", port_addr, 32'h200);
    checkOutput("store_wdata", port_wdata, 32'h11);
    checkOutput("store_size", {30'd0, port_size}, 32'd2);
    waitFor(1, "store_pop_seen");
    sfifo_empty = 1'b1;
    waitFor(0, "load_grant_seen");
    checkOutput("load_we", {31'd0, port_we}, 32'd0);
    checkOutput("load_addr", port_addr, 32'h200);
    checkOutput("load_size", {30'd0, port_size}, 32'd1);
    waitFor(2, "load_valid_seen");
    mem_data_addr_valid = 1'b0;
    repeat (2) @(negedge clk);

    // Fetch flushed while waiting: stale response is dropped, new address issued.
    applyStimulus(1'b1, 32'h100, 1'b0, '0, 2'd0, 1'b1, '0, '0, 2'd0);
    exp_q.push_back('{K_INST, memModel(32'h400), 1'b0});
    @(negedge clk);
    checkOutput("flush_first_addr", port_addr, 32'h100);
    @(negedge clk);
    mem_fetch_addr = 32'h400;
    @(negedge clk);
    checkOutput("flush_stale_dropped", {31'd0, mem_inst_valid}, 32'd0);
    waitFor(0, "flush_regrant_seen");
    checkOutput("flush_new_addr", port_addr, 32'h400);
    waitFor(3, "flush_valid_seen");
    mem_fetch_addr_en = 1'b0;
    repeat (2) @(negedge clk);

    // Starvation: four load grants, then forced fetch, then loads resume.
    applyStimulus(1'b1, 32'h500, 1'b1, 32'h600, 2'd2, 1'b1, '0, '0, 2'd0);
    for (int g = 0; g < 6; g++) begin
      if (starve_seq[g] == 32'h500) exp_q.push_back('{K_INST, memModel(32'h500), 1'b0});
      else                          exp_q.push_back('{K_DATA, memModel(32'h600), 1'b0});
    end
    for (int g = 0; g < 6; g++) begin
      waitFor(0, "starve_grant_seen");
      checkOutput("starve_grant_addr", port_addr, starve_seq[g]);
    end
    mem_fetch_addr_en   = 1'b0;
    mem_data_addr_valid = 1'b0;
    repeat (4) @(negedge clk);

    // Store to a faulting address.
    applyStimulus(1'b0, '0, 1'b0, '0, 2'd0, 1'b0, 32'h8000_0000, 32'h33, 2'd2);
    exp_q.push_back('{K_STORE, 32'h8000_0000, 1'b1});
    waitFor(1, "fault_pop_seen");
    checkOutput("store_fault", {31'd0, store_fault}, 32'd1);
    checkOutput("store_fault_addr", store_fault_addr, 32'h8000_0000);
    sfifo_empty = 1'b1;
    repeat (2) @(negedge clk);

    // Reset while waiting; the late response must be ignored.
    resp_delay = 2;
    applyStimulus(1'b1, 32'h700, 1'b0, '0, 2'd0, 1'b1, '0, '0, 2'd0);
    @(negedge clk);
    checkOutput("rst_req_issued", {31'd0, port_req}, 32'd1);
    @(negedge clk);
    checkOutput("rst_in_wait", {31'd0, port_req}, 32'd0);
    reset = 1'b1;
    mem_fetch_addr_en = 1'b0;
    @(negedge clk);
    checkOutput("rst_port_addr", port_addr, 32'd0);
    checkOutput("rst_inst_in", mem_inst_in, 32'd0);
    checkOutput("rst_data_in", mem_data_in, 32'd0);
    checkOutput("rst_fault_addr", store_fault_addr, 32'd0);
    checkOutput("rst_port_we", {31'd0, port_we}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("late_rvalid_ignored", {30'd0, mem_inst_valid, port_req}, 32'd0);
    end
    resp_delay = 0;

    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-outstanding memory port between three requesters: pipeline instruction fetch, pipeline data read (load), and the store data FIFO drain.
- Sits between `pipeline` and the memory/bus interface.
- Only one transaction is ever in flight.
- Enforces store-before-load ordering and bounds fetch starvation.

Parameters:
- FETCH_MAX_WAIT, 4: number of consecutive grants fetch may lose while requesting before it gets forced priority (1..15).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- mem_fetch_addr  in  32  fetch address
- mem_fetch_addr_en  in  1  fetch request level
- mem_inst_in  out  32  fetch read data
- mem_inst_valid  out  1  fetch response pulse
- mem_inst_access_fault  out  1  fetch fault, qualified by mem_inst_valid
- mem_data_addr  in  32  load address
- mem_data_addr_valid  in  1  load request level
- mem_data_size  in  2  load size (0=byte, 1=half, 2=word)
- mem_data_in  out  32  load read data
- mem_data_valid  out  1  load response pulse
- mem_data_access_fault  out  1  load fault, qualified by mem_data_valid
- sfifo_empty  in  1  store FIFO empty
- sfifo_addr  in  32  head store address
- sfifo_val  in  32  head store data
- sfifo_size  in  2  head store size
- sfifo_pop  out  1  pop pulse, head consumed
- store_fault  out  1  store fault pulse
- store_fault_addr  out  32  address of faulting store
- port_addr  out  32  memory port address
- port_wdata  out  32  memory port write data
- port_size  out  2  memory port size
- port_we  out  1  1=write
- port_req  out  1  request, held until port_ready
- port_ready  in  1  request accepted this cycle
- port_rdata  in  32  read data
- port_rvalid  in  1  response (read data or write ack)
- port_fault  in  1  access fault, qualified by port_rvalid

Behaviour:
- Reset:
  - State returns to IDLE and the starvation counter clears.
  - All outputs go to 0: port_req, port_we, sfifo_pop, every valid, fault and data output.
  - The memory port shares this reset; an in-flight transaction is abandoned with no response or pop.
- States: IDLE, REQ, WAIT, RESP. Granted requester held in `owner` ∈ {FETCH, LOAD, STORE}.
- IDLE arbitration, priority order:
  1. FETCH, if fetch is requesting and starve_cnt ≥ FETCH_MAX_WAIT.
  2. STORE, if !sfifo_empty.
  3. LOAD, if mem_data_addr_valid and sfifo_empty (loads never pass pending stores).
  4. FETCH, if requesting.
- On a grant:
  - Register addr/size/wdata/we into the port outputs (write data from sfifo_val; we=1 only for STORE).
  - Latch the granted fetch address.
  - Set port_req=1 next cycle and go to REQ.
- No request in IDLE: stay in IDLE.
- starve_cnt, saturating at 15, updated only at IDLE grants:
  - Clears when FETCH is granted or fetch is not requesting.
  - Increments when fetch is requesting and another owner is granted.
- REQ:
  - Hold port_* stable with port_req=1 until port_ready.
  - On port_ready, drop port_req next cycle and go to WAIT.
- WAIT: on port_rvalid, capture rdata/fault and go to RESP.
- port_rvalid outside WAIT is ignored. The port never responds in the same cycle as acceptance.
- RESP (one cycle), one-cycle pulse on the owner's response, then IDLE:
  - FETCH: mem_inst_valid pulses only if mem_fetch_addr_en is still 1 and mem_fetch_addr equals the latched address. Otherwise the response is silently dropped (stale after flush).
  - LOAD: mem_data_valid pulses unconditionally. The pipeline holds the load until its response arrives.
  - STORE: sfifo_pop=1. If fault, store_fault=1 with store_fault_addr set to the latched address.
- Response outputs are registered.
- Latency:
  - Request seen in IDLE at cycle 0; port_req from cycle 1.
  - With port_ready at cycle 1 and rvalid at cycle 2, RESP and the response pulse occur at cycle 3.
  - The next grant decision is made in the cycle after RESP, giving 4 cycles per access minimum.
- Fault responses still deliver port_rdata on the data output; consumers ignore it.
- A requester deasserting before its grant costs nothing.
- A requester deasserting after its grant does not abort the port transaction.

Test Plan:
- Fetch only: addr_en=1 with addr=0x100, port_ready=1 immediately, rvalid one cycle later with rdata=0xDEADBEEF.
  -> port_req cycle 1, mem_inst_valid pulse cycle 3 with data 0xDEADBEEF.
- Store FIFO holding 0x200/0x11/word, plus a simultaneous load to 0x200.
  -> store is issued first (port_we=1), sfifo_pop pulses, load is issued only after sfifo_empty=1.
- Fetch flush: fetch to 0x100 granted, then addr changes to 0x400 while in WAIT.
  -> no mem_inst_valid for 0x100, next grant uses 0x400.
- Starvation: FETCH_MAX_WAIT=4, fetch requesting while loads are continuously requested.
  -> 4 load grants, then fetch granted, starve_cnt returns to 0.
- Store fault: port_fault=1 on a store to 0x8000_0000.
  -> store_fault pulse with store_fault_addr=0x8000_0000, sfifo_pop=1.
- Reset asserted in WAIT.
  -> next cycle IDLE with all outputs 0; a late port_rvalid produces no response.
